load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 133 +++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: a three-state FSM that sits between the pipeline and a word-wide data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned and unsupported accesses; otherwise those are force-aligned.
module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_wr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_next;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  req_illegal;
  logic [DATA_W-1:0]     load_data;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;

  // funct3[1:0] selects the access size; the unused encodings only matter when trapping.
`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) ||
                       ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign rsp_err = err_q;
`else
  assign req_illegal = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = req_illegal ? RESP : ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane selection ignores address bits below the access size, which gives force-alignment for free.
  always_comb begin
    load_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    load_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_data = {{(DATA_W-8){load_byte[7]}}, load_byte};
      3'b100:  load_data = {{(DATA_W-8){1'b0}}, load_byte};
      3'b001:  load_data = {{(DATA_W-16){load_half[15]}}, load_half};
      3'b101:  load_data = {{(DATA_W-16){1'b0}}, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
      end else if (state == ACCESS) begin
        rdata_q  <= we_q ? '0 : load_data;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        err_q <= 1'b0;
    else if (state == IDLE && req_valid) err_q <= req_illegal;
  end
`endif

  // Memory-side outputs are only live during ACCESS so a reset drops them combinationally.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_rdata = rdata_q;
    mem_addr  = '0;
    mem_wr    = 4'b0000;
    mem_wdata = '0;
    if (state == ACCESS) begin
      mem_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
      case (funct3_q[1:0])
        2'b00: begin
          mem_wdata = {(DATA_W/8){wdata_q[7:0]}};
          if (we_q) mem_wr = 4'b0001 << addr_q[1:0];
        end
        2'b01: begin
          mem_wdata = {(DATA_W/16){wdata_q[15:0]}};
          if (we_q) mem_wr = 4'b0011 << {addr_q[1], 1'b0};
        end
        default: begin
          mem_wdata = wdata_q;
          if (we_q) mem_wr = 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level memory model, randomized loads/stores, reset abort.
// Follows LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wr;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;

  typedef struct {logic [31:0] rdata; logic err;} rsp_t;
  typedef struct {logic [8:0] addr; logic [3:0] wr; logic [31:0] wdata;} st_t;

  rsp_t       rsp_q[$];
  st_t        st_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_mem [0:511];
  logic [31:0] dmem [0:127];
  logic        pre_en;
  logic [6:0]  pre_idx;
  logic [31:0] pre_word;
  logic [2:0]  st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  load_store_unit #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Combinational-read data memory, written by the DUT lane enables or by bench preload.
  assign mem_rdata = dmem[mem_addr[8:2]];
  always @(posedge clk) begin
    if (pre_en) dmem[pre_idx] <= pre_word;
    else
      for (int l = 0; l < 4; l++)
        if (mem_wr[l]) dmem[mem_addr[8:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic int sizeOf(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic isIllegal(input logic [2:0] f3, input logic [8:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    return (int'(addr) % sizeOf(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: pops the scoreboards whenever the DUT completes a response or writes memory.
  initial begin
    rsp_t e;
    st_t  s;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_rsp: got rdata 0x%08h with nothing expected", rsp_rdata);
        end else begin
          e = rsp_q.pop_front();
          checkOutput("rsp_rdata", rsp_rdata, e.rdata);
          checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      if (mem_wr != 4'b0000) begin
        if (st_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_write: got mem_wr %b expected 0000", mem_wr);
        end else begin
          s = st_q.pop_front();
          checkOutput("mem_addr", 32'(mem_addr), 32'(s.addr));
          checkOutput("mem_wr", 32'(mem_wr), 32'(s.wr));
          checkOutput("mem_wdata", mem_wdata, s.wdata);
        end
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] word);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = 7'(idx); pre_word = word;
    for (int i = 0; i < 4; i++) model_mem[4*idx + i] = word[8*i +: 8];
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                               input logic [31:0] wdata, input int hold);
    int          sz, base, lat;
    logic        bad;
    rsp_t        r;
    st_t         s;
    logic [31:0] val, held;
    sz   = sizeOf(f3);
    base = int'(addr) & ~(sz - 1);
    bad  = isIllegal(f3, addr);
    r.err = bad; r.rdata = 32'd0;
    if (!bad) begin
      if (we) begin
        s.addr = 9'(base & ~3); s.wr = 4'b0000; s.wdata = 32'd0;
        for (int l = 0; l < 4; l++) begin
          s.wdata[8*l +: 8] = wdata[8*(l % sz) +: 8];
          if (l >= base % 4 && l < base % 4 + sz) s.wr[l] = 1'b1;
        end
        for (int i = 0; i < sz; i++) model_mem[base + i] = wdata[8*i +: 8];
        st_q.push_back(s);
      end else begin
        val = 32'd0;
        for (int i = 0; i < sz; i++) val = val | (32'(model_mem[base + i]) << (8*i));
        if (!f3[2] && sz < 4 && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8*sz));
        r.rdata = val;
      end
    end
    rsp_q.push_back(r);
    @(negedge clk);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 8);
    checkOutput("rsp_latency", 32'(lat), bad ? 32'd1 : 32'd2);
    if (!rsp_valid) return;
    held = rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rdata", rsp_rdata, held);
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
    end
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_rsp", {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  task automatic resetDuringStore();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 9'h020; req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    checkOutput("access_mem_wr", 32'(mem_wr), 32'hF);
    reset = 1'b1;
    #1;
    checkOutput("reset_mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] w;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_word = '0;
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rsp_valid0", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_mem_wr0", 32'(mem_wr), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 128; i++) begin
      w = $urandom;
      preload(i, w);
    end

    applyStimulus(1'b1, 3'b010, 9'h010, 32'hDEAD_BEEF, 0);
    applyStimulus(1'b1, 3'b000, 9'h013, 32'h0000_00A5, 1);
    preload(4, 32'h8011_2233);
    applyStimulus(1'b0, 3'b000, 9'h013, 32'd0, 0);
    applyStimulus(1'b0, 3'b100, 9'h013, 32'd0, 0);
    applyStimulus(1'b0, 3'b101, 9'h012, 32'd0, 2);
    applyStimulus(1'b0, 3'b010, 9'h010, 32'd0, 5);
    applyStimulus(1'b0, 3'b001, 9'h001, 32'd0, 0);
    applyStimulus(1'b1, 3'b001, 9'h003, 32'hCAFE_1234, 0);
    applyStimulus(1'b0, 3'b111, 9'h006, 32'd0, 0);

    for (int t = 0; t < 200; t++)
      applyStimulus(1'($urandom), 3'($urandom_range(0, 7)), 9'($urandom), $urandom, $urandom_range(0, 3));
    for (int t = 0; t < 40; t++)
      applyStimulus(1'b1, st_f3[$urandom_range(0, 5)], 9'($urandom), $urandom, 0);

    resetDuringStore();
    applyStimulus(1'b0, 3'b010, 9'h020, 32'd0, 0);
    for (int t = 0; t < 40; t++)
      applyStimulus(1'b0, 3'($urandom_range(0, 7)), 9'($urandom), 32'd0, $urandom_range(0, 2));

    repeat (2) @(negedge clk);
    checkOutput("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    checkOutput("store_queue_empty", 32'(st_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
